// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : parity_pkg
//  Purpose : Shared types and helpers for the parity frame checker.
//            - pfc_state_t : frame FSM states
//            - PAR_EVEN / PAR_ODD : parity mode encodings
//            - cnt_w / idx_w : counter width helpers
//  Rev     : 1.0  initial release
// ============================================================================
package parity_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } pfc_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of an index that runs 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_parity.sv
`default_nettype none
// ============================================================================
//  Module  : word_parity
//  Purpose : Combinational parity of a data word (1 = odd number of ones).
//  Ports   : data_i [BITS-1:0]  data word
//            par_o               XOR-reduction of data_i
//  Rev     : 1.0  initial release
// ============================================================================
module word_parity #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] data_i,
  output logic            par_o
);

  assign par_o = ^data_i;

endmodule
`default_nettype wire

// File: rtl/parity_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module  : parity_frame_checker
//  Purpose : Streaming per-word parity checker with frame-level accumulation.
//            Flags each accepted word whose parity bit is wrong, and after
//            FRAME words reports the frame's data parity (PF/NF) and the
//            number of word errors. One idle bubble follows every frame.
//  Ports   : i_clk, i_rst (sync, active-high), i_clr (sync frame abort)
//            i_valid / o_ready handshake, i_data [BITS-1:0], i_par
//            o_word_err (1-cycle pulse), o_frame_valid (1-cycle pulse)
//            o_pf, o_nf, o_err_cnt [$clog2(FRAME+1)-1:0]
//            o_sticky_err  (only when PARITY_FRAME_STICKY_EN is defined)
//  Config  : `define PARITY_FRAME_STICKY_EN adds a sticky "any frame had an
//            error" flag, cleared only by i_rst.
//  Rev     : 1.0  initial release
// ============================================================================
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int FRAME = 4,
  parameter int ODD   = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clr,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [BITS-1:0]            i_data,
  input  logic                       i_par,
  output logic                       o_word_err,
  output logic                       o_frame_valid,
  output logic                       o_pf,
  output logic                       o_nf,
  output logic [cnt_w(FRAME)-1:0]    o_err_cnt
`ifdef PARITY_FRAME_STICKY_EN
  ,
  output logic                       o_sticky_err
`endif
);

  localparam int              CW       = cnt_w(FRAME);
  localparam int              IW       = idx_w(FRAME);
  localparam logic [IW-1:0]   LAST_IDX = IW'(FRAME - 1);
  localparam logic            ODD_BIT  = (ODD != 0) ? PAR_ODD : PAR_EVEN;

  pfc_state_t      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            acc_par_q, acc_par_d;
  logic [CW-1:0]   acc_err_q, acc_err_d;
  logic            pf_q, pf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic            fv_q, fv_d;

  logic            w_p;
  logic            w_err;
  logic            w_accept;
  logic            w_last;

  word_parity #(.BITS(BITS)) u_word_parity (
    .data_i (i_data),
    .par_o  (w_p)
  );

  // The transmitted bit is expected to equal data parity, inverted in odd mode.
  assign w_err    = (i_par != (w_p ^ ODD_BIT));
  assign o_ready  = (state_q != S_DONE) && !i_clr;
  assign w_accept = i_valid && o_ready;
  // idx is 0 in S_IDLE, so with FRAME=1 the first word is also the last.
  assign w_last   = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    if (i_clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (w_accept) state_d = w_last ? S_DONE : S_ACCUM;
        S_ACCUM: if (w_accept && w_last) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    idx_d     = idx_q;
    acc_par_d = acc_par_q;
    acc_err_d = acc_err_q;
    pf_d      = pf_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    fv_d      = 1'b0;
    if (i_clr) begin
      // Abort the partial frame; the last completed results stay visible.
      idx_d     = '0;
      acc_par_d = 1'b0;
      acc_err_d = '0;
    end else if (w_accept) begin
      we_d = w_err;
      if (w_last) begin
        pf_d      = acc_par_q ^ w_p;
        cnt_d     = acc_err_q + CW'(w_err);
        fv_d      = 1'b1;
        idx_d     = '0;
        acc_par_d = 1'b0;
        acc_err_d = '0;
      end else begin
        idx_d     = idx_q + IW'(1);
        acc_par_d = acc_par_q ^ w_p;
        acc_err_d = acc_err_q + CW'(w_err);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      acc_par_q <= 1'b0;
      acc_err_q <= '0;
      pf_q      <= 1'b0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      fv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_par_q <= acc_par_d;
      acc_err_q <= acc_err_d;
      pf_q      <= pf_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      fv_q      <= fv_d;
    end
  end

  assign o_word_err    = we_q;
  assign o_frame_valid = fv_q;
  assign o_pf          = pf_q;
  assign o_nf          = ~pf_q;
  assign o_err_cnt     = cnt_q;

`ifdef PARITY_FRAME_STICKY_EN
  logic sticky_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sticky_q <= 1'b0;
    end else if (fv_d && (cnt_d != '0)) begin
      sticky_q <= 1'b1;
    end
  end

  assign o_sticky_err = sticky_q;
`endif

endmodule
`default_nettype wire
